// File: rtl/arb_grant_collector.sv
// Requester-side front end for an external N-way arbiter. It collects client requests,
// checks the returned grant, and queues the winning payload in a 2-entry FIFO.
module arb_grant_collector #(
    parameter int N  = 8,
    parameter int DW = 32,
    parameter int SW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    in_valid,
    input  logic [N*DW-1:0] in_data,
    output logic [N-1:0]    in_ready,
    output logic [N-1:0]    req,
    input  logic [N-1:0]    grant,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [SW-1:0]   out_src,
    input  logic            out_ready,
    output logic            grant_err
);

    logic [1:0]    r_count;
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [DW-1:0] r_data [2];
    logic [SW-1:0] r_src  [2];
    logic          r_err;

    logic          w_space;
    logic          w_onehot;
    logic          w_legal;
    logic          w_bad;
    logic          w_push;
    logic          w_pop;
    logic [SW-1:0] w_idx;
    logic [DW-1:0] w_sel;

    assign w_space  = (r_count != 2'd2);
    assign req      = in_valid & {N{w_space}};
    assign w_onehot = (grant != '0) && ((grant & (grant - N'(1))) == '0);
    // Checking against req also rejects any grant while full, since req is then zero.
    assign w_legal  = w_onehot && ((grant & ~req) == '0);
    assign w_bad    = (grant != '0) && !w_legal;
    assign w_push   = w_legal;
    assign w_pop    = out_valid && out_ready;
    assign in_ready = w_legal ? grant : '0;

    always_comb begin
        w_idx = '0;
        w_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                w_idx = w_idx | SW'(i);
                w_sel = w_sel | in_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_err    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_data[i] <= '0;
                r_src[i]  <= '0;
            end
        end else begin
            if (w_push) begin
                r_data[r_wr_ptr] <= w_sel;
                r_src[r_wr_ptr]  <= w_idx;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            r_err <= r_err | w_bad;
        end
    end

    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_data[r_rd_ptr];
    assign out_src   = r_src[r_rd_ptr];
    assign grant_err = r_err;

endmodule

// File: tb/tb_arb_grant_collector.sv
// Directed bench for arb_grant_collector: a reference model of req/ack/error plus a
// scoreboard queue of expected {src, data} beats compared as the FIFO drains.
module tb_arb_grant_collector;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int SW = 3;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic [N-1:0]    req;
    logic [N-1:0]    grant;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_src;
    logic            out_ready;
    logic            grant_err;

    arb_grant_collector #(.N(N), .DW(DW), .SW(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .req       (req),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .grant_err (grant_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [SW+DW-1:0] exp_q[$];
    int               n_assert;
    int               n_fail;
    logic [DW-1:0]    dat [N];
    logic [N-1:0]     vld;
    logic             drop_on_ack;
    logic             exp_err;
    int               rr_ptr;

    localparam int M_IDLE = 0;
    localparam int M_FP   = 1;
    localparam int M_RR   = 2;
    localparam int M_EXP  = 3;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = dat[i];
    endtask

    // Called just after a rising edge; drives one cycle, checks, models, returns after next edge.
    task automatic cycle(input int mode, input logic [N-1:0] g_exp, input logic ordy);
        logic [N-1:0]  m_req;
        logic [N-1:0]  g;
        logic          m_legal;
        logic [SW-1:0] idx;
        m_req = vld & {N{exp_q.size() < 2}};
        g = '0;
        case (mode)
            M_FP:  g = m_req & ~(m_req - N'(1));
            M_RR: begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (rr_ptr + k) % N;
                    if (g == '0 && m_req[j]) g = N'(1) << j;
                end
            end
            M_EXP: g = g_exp;
            default: g = '0;
        endcase
        m_legal = ($countones(g) == 1) && ((g & ~m_req) == '0);
        in_valid  = vld;
        drive_data();
        grant     = g;
        out_ready = ordy;
        #2;
        chk("req", 64'(req), 64'(m_req));
        chk("in_ready", 64'(in_ready), m_legal ? 64'(g) : 64'd0);
        chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        chk("grant_err", 64'(grant_err), 64'(exp_err));
        if (exp_q.size() != 0) begin
            chk("head", 64'({out_src, out_data}), 64'(exp_q[0]));
            if (ordy) void'(exp_q.pop_front());
        end
        if (m_legal) begin
            idx = '0;
            for (int i = 0; i < N; i++) if (g[i]) idx = SW'(i);
            exp_q.push_back({idx, dat[idx]});
            if (drop_on_ack) vld[idx] = 1'b0;
            dat[idx] = $urandom;
            rr_ptr = (int'(idx) + 1) % N;
        end
        if (g != '0 && !m_legal) exp_err = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        grant    = '0;
        in_valid = vld;
        rst_n    = 1'b0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_grant_err", 64'(grant_err), 64'd0);
        chk("rst_req", 64'(req), 64'(vld));
        exp_q.delete();
        exp_err = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        exp_err  = 1'b0;
        rr_ptr   = 0;
        drop_on_ack = 1'b1;
        for (int i = 0; i < N; i++) dat[i] = $urandom;
        vld       = 8'h5A;
        rst_n     = 1'b0;
        in_valid  = vld;
        grant     = '0;
        out_ready = 1'b0;
        drive_data();
        #3;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data", 64'(out_data), 64'd0);
        chk("reset_out_src", 64'(out_src), 64'd0);
        chk("reset_grant_err", 64'(grant_err), 64'd0);
        chk("reset_req", 64'(req), 64'h5A);
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single client
        vld = 8'h04;
        dat[2] = 32'hA5A5_0002;
        in_valid = vld;
        drive_data();
        #1;
        chk("single_req", 64'(req), 64'h04);
        cycle(M_FP, '0, 1'b1);
        chk("single_out_data", 64'(out_data), 64'hA5A5_0002);
        chk("single_out_src", 64'(out_src), 64'd2);
        cycle(M_IDLE, '0, 1'b1);

        // backpressure with fixed priority
        vld = 8'hFF;
        cycle(M_FP, '0, 1'b0);
        cycle(M_FP, '0, 1'b0);
        cycle(M_FP, '0, 1'b0);
        cycle(M_EXP, 8'h01, 1'b0);
        vld = 8'hFF;
        drop_on_ack = 1'b0;
        cycle(M_FP, '0, 1'b1);
        cycle(M_FP, '0, 1'b1);
        cycle(M_IDLE, '0, 1'b1);
        cycle(M_IDLE, '0, 1'b1);

        // streaming round robin
        rr_ptr = 0;
        repeat (20) cycle(M_RR, '0, 1'b1);
        cycle(M_IDLE, '0, 1'b1);

        // illegal multi-bit grant, error held through legal traffic
        cycle(M_EXP, 8'h06, 1'b1);
        repeat (4) cycle(M_FP, '0, 1'b1);
        cycle(M_IDLE, '0, 1'b1);

        // idle grants never flag an error
        rst_pulse();
        repeat (100) cycle(M_IDLE, '0, 1'b1);

        // grant to a non-requesting client
        vld = 8'h01;
        cycle(M_EXP, 8'h10, 1'b1);
        cycle(M_IDLE, '0, 1'b1);

        // fill FIFO with error set, then asynchronous reset
        vld = 8'hFF;
        cycle(M_FP, '0, 1'b0);
        cycle(M_FP, '0, 1'b0);
        cycle(M_IDLE, '0, 1'b0);
        rst_pulse();
        vld = 8'h20;
        drop_on_ack = 1'b1;
        cycle(M_FP, '0, 1'b1);
        cycle(M_IDLE, '0, 1'b1);
        cycle(M_IDLE, '0, 1'b1);

        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
